// File: rtl/gcd_ctrl_dp.sv
// Subtract-based GCD engine: control FSM plus X/Y operand registers fed by 2:1 muxes.
// Operands come in on a start/ready handshake; the result leaves on res_valid/res_ready.
module gcd_ctrl_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             x_sel,
    output logic             y_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] term_val;

    // Zero X returns Y (covers gcd(0,0)=0); zero Y or X==Y returns X.
    assign term_val = (x_q == '0) ? y_q : x_q;
    assign accept   = (state == IDLE) && start;

    // Operand muxes: sel=0 loads the input operand, sel=1 loads the difference.
    assign x_d = x_sel ? (x_q - y_q) : a_in;
    assign y_d = y_sel ? (y_q - x_q) : b_in;

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        x_sel    = 1'b0;
        y_sel    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = CALC;
            end
            CALC: begin
                if ((x_q == '0) || (y_q == '0) || (x_q == y_q)) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else if (x_q > y_q) begin
                    x_sel = 1'b1;
                end else begin
                    y_sel = 1'b1;
                end
            end
            DONE: begin
                if (res_valid && res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (accept || x_sel) x_q <= x_d;
            if (accept || y_sel) y_q <= y_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
        end else if ((x_sel || y_sel) && (iter_cnt != '1)) begin
            iter_cnt <= iter_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (finish) begin
            result <= term_val;
        end
    end

    // res_valid rises one cycle after entering DONE; consumption is only honoured once it is up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
        end else if (state == DONE) begin
            if (!res_valid) begin
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end else begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gcd_ctrl_dp.sv
// Scoreboard bench for gcd_ctrl_dp: expected jobs are queued when driven, popped when res_valid appears.
module tb_gcd_ctrl_dp;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             x_sel;
    logic             y_sel;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] iter_cnt;

    typedef struct {
        int a;
        int b;
        int res;
        int iters;
        int lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    gcd_ctrl_dp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready     (ready),
        .x_sel     (x_sel),
        .y_sel     (y_sel),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_gcd(input int a, input int b);
        exp_t e;
        int x = a;
        int y = b;
        int n = 0;
        e.a = a;
        e.b = b;
        forever begin
            if (x == 0) begin e.res = y; break; end
            if (y == 0) begin e.res = x; break; end
            if (x == y) begin e.res = x; break; end
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        e.iters = (n > 15) ? 15 : n;
        e.lat   = n + 2;
        return e;
    endfunction

    // Run one job; hold>0 keeps res_ready low that many cycles in DONE and pokes start meanwhile.
    task automatic run_job(input int a, input int b, input int hold);
        exp_t e;
        int   lat;
        int   xs;
        int   ys;
        int   w;
        int   r0;
        int   i0;
        w = 0;
        while (!ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_val("ready_before_start", int'(ready), 1);
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        start = 1'b1;
        sb_q.push_back(ref_gcd(a, b));
        @(posedge clk); #1;
        start = 1'b0;
        check_val("ready_low_busy", int'(ready), 0);
        lat = 0; xs = 0; ys = 0;
        while (!res_valid && lat < 40) begin
            if (x_sel) xs++;
            if (y_sel) ys++;
            check_val("sel_exclusive", int'(x_sel & y_sel), 0);
            if (lat == 1) begin
                start = 1'b1;
                a_in  = 4'd3;
                b_in  = 4'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        e = sb_q.pop_front();
        check_val($sformatf("lat_%0d_%0d", a, b), lat, e.lat);
        check_val($sformatf("res_%0d_%0d", a, b), int'(result), e.res);
        check_val($sformatf("iter_%0d_%0d", a, b), int'(iter_cnt), e.iters);
        if (a == 15 && b == 1) begin
            check_val("xsel_pulses", xs, 14);
            check_val("ysel_pulses", ys, 0);
        end
        if (hold > 0) begin
            r0 = int'(result);
            i0 = int'(iter_cnt);
            for (int k = 0; k < hold; k++) begin
                start = (k == 2);
                @(posedge clk); #1;
                check_val("hold_valid", int'(res_valid), 1);
                check_val("hold_result", int'(result), r0);
                check_val("hold_iter", int'(iter_cnt), i0);
                check_val("hold_ready", int'(ready), 0);
            end
            start = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val("valid_drop", int'(res_valid), 0);
        check_val("ready_after", int'(ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, int'(ready), 1);
        check_val({tag, "_valid"}, int'(res_valid), 0);
        check_val({tag, "_result"}, int'(result), 0);
        check_val({tag, "_iter"}, int'(iter_cnt), 0);
        check_val({tag, "_xsel"}, int'(x_sel), 0);
        check_val({tag, "_ysel"}, int'(y_sel), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(12, 8, 0);
        run_job(5, 5, 0);
        run_job(0, 9, 0);
        run_job(7, 0, 0);
        run_job(0, 0, 0);
        run_job(15, 1, 0);
        run_job(9, 12, 5);

        // Abort a running job with an asynchronous reset pulse mid-cycle.
        a_in = 4'd14; b_in = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(9, 6, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_job(a, b, 0);

        check_val("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
